// File: rtl/radiation_monitor_decoder.sv
// Consumer of the radiation monitor FIFO stream: rebuilds per-module records and keeps the latest one per module.
// Optional address sequence checking is compiled in with `define RAD_MON_DECODER_SEQ_CHECK_EN.
module radiation_monitor_decoder #(
  parameter  int G_MODULES_CONNECTED   = 5,
  parameter  int G_OUTPUT_ARRAY_SIZE   = 8,
  parameter  int G_ADDITIONAL_MISMATCH = 1,
  parameter  int G_ERR_CNT_WIDTH       = 16,
  localparam int MW = ($clog2(G_MODULES_CONNECTED) < 1) ? 1 : $clog2(G_MODULES_CONNECTED)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           fifo_empty_i,
  output logic                           fifo_read_o,
  input  logic [G_OUTPUT_ARRAY_SIZE-1:0] fifo_data_i,
  input  logic [MW-1:0]                  rd_module_i,
  output logic                           rd_valid_o,
  output logic [G_OUTPUT_ARRAY_SIZE-1:0] rd_value_o,
  output logic [G_OUTPUT_ARRAY_SIZE-1:0] rd_count_o,
  output logic [G_OUTPUT_ARRAY_SIZE-1:0] rd_value_2nd_o,
  output logic [G_OUTPUT_ARRAY_SIZE-1:0] rd_count_2nd_o,
  output logic                           record_valid_o,
  output logic [MW-1:0]                  record_module_o,
  output logic                           upset_o,
  output logic [G_ERR_CNT_WIDTH-1:0]     sync_err_cnt_o
);

  localparam int          W        = G_OUTPUT_ARRAY_SIZE;
  localparam int unsigned NMOD     = G_MODULES_CONNECTED;
  localparam bit          HAS_2ND  = (G_ADDITIONAL_MISMATCH != 0);
  localparam logic [MW-1:0] LAST_MOD = MW'(G_MODULES_CONNECTED - 1);

  typedef enum logic [2:0] {
    WAIT_ADDR,
    GET_VALUE,
    GET_COUNT,
    GET_VALUE_2ND,
    GET_COUNT_2ND
  } state_t;

  state_t state_q, state_d;

  logic          dvalid_q;
  logic [MW-1:0] cur_module_q;
  logic [W-1:0]  value_q;
  logic [W-1:0]  count_q;
  logic [W-1:0]  value2_q;

  logic          addr_in_range;
  logic          seq_err;
  logic          err_inc;
  logic          commit;
  logic          upset_d;
  logic [W-1:0]  new_value;
  logic [W-1:0]  new_count;
  logic [W-1:0]  new_value_2nd;
  logic [W-1:0]  new_count_2nd;

  logic          valid_q      [G_MODULES_CONNECTED];
  logic [W-1:0]  value_mem    [G_MODULES_CONNECTED];
  logic [W-1:0]  count_mem    [G_MODULES_CONNECTED];
  logic [W-1:0]  value2_mem   [G_MODULES_CONNECTED];
  logic [W-1:0]  count2_mem   [G_MODULES_CONNECTED];

  logic                       record_valid_q;
  logic [MW-1:0]              record_module_q;
  logic                       upset_q;
  logic [G_ERR_CNT_WIDTH-1:0] sync_err_q;

  // The decoder never back-pressures: any word present is read immediately.
  assign fifo_read_o   = !fifo_empty_i;
  assign addr_in_range = (32'(fifo_data_i) < NMOD);

`ifdef RAD_MON_DECODER_SEQ_CHECK_EN
  logic          have_expected_q;
  logic [MW-1:0] expected_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      have_expected_q <= 1'b0;
      expected_q      <= '0;
    end else if (commit) begin
      have_expected_q <= 1'b1;
      expected_q      <= (cur_module_q == LAST_MOD) ? '0 : cur_module_q + 1'b1;
    end
  end

  assign seq_err = have_expected_q && (MW'(fifo_data_i) != expected_q);
`else
  assign seq_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvalid_q <= 1'b0;
      state_q  <= WAIT_ADDR;
    end else begin
      dvalid_q <= fifo_read_o;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    err_inc = 1'b0;
    if (dvalid_q) begin
      case (state_q)
        WAIT_ADDR: begin
          if (!addr_in_range) begin
            err_inc = 1'b1;
          end else begin
            err_inc = seq_err;
            state_d = GET_VALUE;
          end
        end
        GET_VALUE: state_d = GET_COUNT;
        GET_COUNT: begin
          if (HAS_2ND) begin
            state_d = GET_VALUE_2ND;
          end else begin
            commit  = 1'b1;
            state_d = WAIT_ADDR;
          end
        end
        GET_VALUE_2ND: state_d = GET_COUNT_2ND;
        GET_COUNT_2ND: begin
          commit  = 1'b1;
          state_d = WAIT_ADDR;
        end
        default: state_d = WAIT_ADDR;
      endcase
    end
  end

  // The last word of a record is committed straight from the FIFO bus.
  always_comb begin
    new_value     = value_q;
    new_count     = fifo_data_i;
    new_value_2nd = '0;
    new_count_2nd = '0;
    if (HAS_2ND) begin
      new_count     = count_q;
      new_value_2nd = value2_q;
      new_count_2nd = fifo_data_i;
    end
  end

  assign upset_d = commit && valid_q[cur_module_q] &&
                   ((new_count != count_mem[cur_module_q]) ||
                    (new_count_2nd != count2_mem[cur_module_q]));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_module_q <= '0;
      value_q      <= '0;
      count_q      <= '0;
      value2_q     <= '0;
    end else if (dvalid_q) begin
      case (state_q)
        WAIT_ADDR:     if (addr_in_range) cur_module_q <= MW'(fifo_data_i);
        GET_VALUE:     value_q  <= fifo_data_i;
        GET_COUNT:     count_q  <= fifo_data_i;
        GET_VALUE_2ND: value2_q <= fifo_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < G_MODULES_CONNECTED; i++) begin
        valid_q[i]    <= 1'b0;
        value_mem[i]  <= '0;
        count_mem[i]  <= '0;
        value2_mem[i] <= '0;
        count2_mem[i] <= '0;
      end
    end else if (commit) begin
      valid_q[cur_module_q]    <= 1'b1;
      value_mem[cur_module_q]  <= new_value;
      count_mem[cur_module_q]  <= new_count;
      value2_mem[cur_module_q] <= new_value_2nd;
      count2_mem[cur_module_q] <= new_count_2nd;
    end
  end

  // Error count saturates so a long-running misaligned stream stays visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      record_valid_q  <= 1'b0;
      record_module_q <= '0;
      upset_q         <= 1'b0;
      sync_err_q      <= '0;
    end else begin
      record_valid_q <= commit;
      upset_q        <= upset_d;
      if (commit) record_module_q <= cur_module_q;
      if (err_inc && (sync_err_q != '1)) sync_err_q <= sync_err_q + 1'b1;
    end
  end

  assign record_valid_o  = record_valid_q;
  assign record_module_o = record_module_q;
  assign upset_o         = upset_q;
  assign sync_err_cnt_o  = sync_err_q;

  always_comb begin
    rd_valid_o     = 1'b0;
    rd_value_o     = '0;
    rd_count_o     = '0;
    rd_value_2nd_o = '0;
    rd_count_2nd_o = '0;
    if (32'(rd_module_i) < NMOD) begin
      rd_valid_o     = valid_q[rd_module_i];
      rd_value_o     = value_mem[rd_module_i];
      rd_count_o     = count_mem[rd_module_i];
      rd_value_2nd_o = value2_mem[rd_module_i];
      rd_count_2nd_o = count2_mem[rd_module_i];
    end
  end

endmodule

// File: tb/tb_radiation_monitor_decoder.sv
// Scoreboard bench for radiation_monitor_decoder: record-level model, FIFO model and decoupled monitor.
module tb_radiation_monitor_decoder;

  localparam int N   = 5;
  localparam int W   = 8;
  localparam int ADD = 1;
  localparam int EW  = 16;
  localparam int MW  = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic          fifo_read_o;
  logic [W-1:0]  fifo_data_i = '0;
  logic [MW-1:0] rd_module_i = '0;
  logic          rd_valid_o;
  logic [W-1:0]  rd_value_o, rd_count_o, rd_value_2nd_o, rd_count_2nd_o;
  logic          record_valid_o;
  logic [MW-1:0] record_module_o;
  logic          upset_o;
  logic [EW-1:0] sync_err_cnt_o;

  radiation_monitor_decoder #(
    .G_MODULES_CONNECTED(N),
    .G_OUTPUT_ARRAY_SIZE(W),
    .G_ADDITIONAL_MISMATCH(ADD),
    .G_ERR_CNT_WIDTH(EW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .fifo_empty_i(fifo_empty_i),
    .fifo_read_o(fifo_read_o),
    .fifo_data_i(fifo_data_i),
    .rd_module_i(rd_module_i),
    .rd_valid_o(rd_valid_o),
    .rd_value_o(rd_value_o),
    .rd_count_o(rd_count_o),
    .rd_value_2nd_o(rd_value_2nd_o),
    .rd_count_2nd_o(rd_count_2nd_o),
    .record_valid_o(record_valid_o),
    .record_module_o(record_module_o),
    .upset_o(upset_o),
    .sync_err_cnt_o(sync_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [MW-1:0] mod;
    logic          upset;
  } exp_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  bit         gap_mode = 1'b0;

  // Reference model: latest record per module plus the expected error count
  bit         m_valid [N];
  logic [7:0] m_val   [N];
  logic [7:0] m_cnt   [N];
  logic [7:0] m_val2  [N];
  logic [7:0] m_cnt2  [N];
  int         m_err;
`ifdef RAD_MON_DECODER_SEQ_CHECK_EN
  bit         m_have_last;
  int         m_last;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_val[i] = '0; m_cnt[i] = '0; m_val2[i] = '0; m_cnt2[i] = '0;
    end
    m_err = 0;
`ifdef RAD_MON_DECODER_SEQ_CHECK_EN
    m_have_last = 1'b0;
    m_last = 0;
`endif
    exp_q.delete();
  endtask

  task automatic applyStimulus(input int mod, input logic [7:0] v, input logic [7:0] c,
                               input logic [7:0] v2, input logic [7:0] c2);
    bit up;
    logic [7:0] sv2, sc2;
    sv2 = (ADD != 0) ? v2 : 8'h00;
    sc2 = (ADD != 0) ? c2 : 8'h00;
`ifdef RAD_MON_DECODER_SEQ_CHECK_EN
    if (m_have_last && mod != (m_last + 1) % N) m_err++;
    m_have_last = 1'b1;
    m_last = mod;
`endif
    up = m_valid[mod] && ((c != m_cnt[mod]) || (sc2 != m_cnt2[mod]));
    fifo_q.push_back(8'(mod));
    fifo_q.push_back(v);
    fifo_q.push_back(c);
    if (ADD != 0) begin
      fifo_q.push_back(v2);
      fifo_q.push_back(c2);
    end
    m_valid[mod] = 1'b1;
    m_val[mod] = v; m_cnt[mod] = c; m_val2[mod] = sv2; m_cnt2[mod] = sc2;
    exp_q.push_back('{mod: MW'(mod), upset: up});
  endtask

  task automatic sendBad(input logic [7:0] w);
    fifo_q.push_back(w);
    if (m_err < (1 << EW) - 1) m_err++;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain_in_time", 32'(n < 2000), 32'd1);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic checkRegFile(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_module_i = 3'(i);
      #1;
      if (i < N) begin
        checkOutput($sformatf("%s_m%0d_valid", tag, i), 32'(rd_valid_o), 32'(m_valid[i]));
        checkOutput($sformatf("%s_m%0d_value", tag, i), 32'(rd_value_o), 32'(m_val[i]));
        checkOutput($sformatf("%s_m%0d_count", tag, i), 32'(rd_count_o), 32'(m_cnt[i]));
        checkOutput($sformatf("%s_m%0d_value2", tag, i), 32'(rd_value_2nd_o), 32'(m_val2[i]));
        checkOutput($sformatf("%s_m%0d_count2", tag, i), 32'(rd_count_2nd_o), 32'(m_cnt2[i]));
      end else begin
        checkOutput($sformatf("%s_sel%0d_zero", tag, i),
                    {rd_valid_o, rd_value_o, rd_count_o, rd_value_2nd_o, rd_count_2nd_o}, 32'd0);
      end
    end
    checkOutput({tag, "_sync_err"}, 32'(sync_err_cnt_o), 32'(m_err));
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    modelClear();
    rst_ni = 1'b1;
  endtask

  // FIFO model: a read at one edge presents the popped word just after that edge.
  initial begin
    bit rd_now;
    bit ph;
    ph = 1'b0;
    forever begin
      @(posedge clk_i);
      rd_now = fifo_read_o;
      #1;
      if (rd_now && fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
      ph = ~ph;
      fifo_empty_i = (fifo_q.size() == 0) || (gap_mode && ph);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a committed record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        checkOutput("fifo_read", 32'(fifo_read_o), 32'(!fifo_empty_i));
        if (exp_q.size() == 0) begin
          checkOutput("spurious_record", 32'(record_valid_o), 32'd0);
        end else if (record_valid_o) begin
          e = exp_q.pop_front();
          checkOutput("record_module", 32'(record_module_o), 32'(e.mod));
          checkOutput($sformatf("upset_m%0d", e.mod), 32'(upset_o), 32'(e.upset));
        end
        if (!record_valid_o) checkOutput("upset_idle", 32'(upset_o), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] c, c2;
    int mod;
    modelClear();
    doReset();
    checkOutput("rst_record_valid", 32'(record_valid_o), 32'd0);
    checkOutput("rst_upset", 32'(upset_o), 32'd0);
    checkOutput("rst_record_module", 32'(record_module_o), 32'd0);
    checkOutput("rst_fifo_read", 32'(fifo_read_o), 32'(!fifo_empty_i));
    checkRegFile("reset");

    // First full pass; module 2 carries the fixed pattern
    for (int m = 0; m < N; m++) begin
      if (m == 2)      applyStimulus(2, 8'h0F, 8'h03, 8'h0F, 8'h00);
      else if (m == 1) applyStimulus(1, 8'($urandom), 8'hFF, 8'($urandom), 8'h11);
      else if (m == 3) applyStimulus(3, 8'($urandom), 8'h03, 8'($urandom), 8'h22);
      else             applyStimulus(m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    waitDrain();
    checkRegFile("pass1");

    // Second pass: only module 3 (0x03->0x04) and module 1 (0xFF->0x00) counters move
    for (int m = 0; m < N; m++) begin
      c = m_cnt[m];
      if (m == 3) c = 8'h04;
      if (m == 1) c = 8'h00;
      applyStimulus(m, 8'($urandom), c, 8'($urandom), m_cnt2[m]);
    end
    waitDrain();
    checkRegFile("pass2");

    sendBad(8'h07);
    applyStimulus(0, 8'h5A, m_cnt[0], 8'hA5, m_cnt2[0]);
    waitDrain();
    checkRegFile("oob");

    gap_mode = 1'b1;
    for (int m = 1; m < N; m++)
      applyStimulus(m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    waitDrain();
    gap_mode = 1'b0;
    checkRegFile("gapped");

    foreach (fifo_q[i]) ; // keep order: sequence 0,1,3,4
    applyStimulus(0, 8'h01, m_cnt[0], 8'h02, m_cnt2[0]);
    applyStimulus(1, 8'h03, m_cnt[1], 8'h04, m_cnt2[1]);
    applyStimulus(3, 8'h05, m_cnt[3], 8'h06, m_cnt2[3]);
    applyStimulus(4, 8'h07, m_cnt[4], 8'h08, m_cnt2[4]);
    waitDrain();
    checkRegFile("seq");

    // Reset while module 2's record sits after its counter word
    applyStimulus(0, 8'h10, 8'h20, 8'h30, 8'h40);
    applyStimulus(1, 8'h11, 8'h21, 8'h31, 8'h41);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'h22);
    waitDrain();
    doReset();
    checkOutput("midrst_record_module", 32'(record_module_o), 32'd0);
    checkRegFile("midrst");
    applyStimulus(3, 8'h33, 8'h44, 8'h55, 8'h66);
    waitDrain();
    checkRegFile("after_rst");

    // Randomised traffic with occasional bad addresses and gaps
    for (int k = 0; k < 60; k++) begin
      if (k % 10 == 0) gap_mode = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) sendBad(8'($urandom_range(N, 255)));
      mod = (k % 3 == 0) ? int'($urandom_range(0, N - 1)) : (k % N);
      c  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_cnt[mod];
      c2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_cnt2[mod];
      applyStimulus(mod, 8'($urandom), c, 8'($urandom), c2);
      if (k % 15 == 14) begin
        waitDrain();
        checkRegFile($sformatf("rand%0d", k));
      end
    end
    gap_mode = 1'b0;
    waitDrain();
    checkRegFile("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
